// File: rtl/bcd_hex_display_if.sv
// rtl/bcd_hex_display_if.sv - value handshake and display outputs of the BCD display stage
interface bcd_hex_display_if #(
  parameter int BIN_W = 7,
  parameter int NDIG  = 2
);
  logic             in_valid;
  logic [BIN_W-1:0] in_bin;
  logic             in_ready;
  logic             blank_lz;
  logic [NDIG*8-1:0] hex_out;
  logic             conv_done;

  modport master (
    output in_valid, in_bin, blank_lz,
    input  in_ready, hex_out, conv_done
  );

  modport slave (
    input  in_valid, in_bin, blank_lz,
    output in_ready, hex_out, conv_done
  );
endinterface

// File: rtl/bcd_hex_display.sv
// rtl/bcd_hex_display.sv - serial double-dabble binary to active-low 7-segment display stage
module bcd_hex_display #(
  parameter int BIN_W = 7,
  parameter int NDIG  = 2
) (
  input  logic               ADC_CLK_10,
  input  logic               reset,
  bcd_hex_display_if.slave   bus
);

  function automatic int bcd_digits(input int w);
    longint v;
    int     n;
    v = (longint'(1) << w) - 1;
    n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return (n < 1) ? 1 : n;
  endfunction

  localparam int NBCD = bcd_digits(BIN_W);
  // Keep at least NDIG nibbles so display indexing never runs past the shift register.
  localparam int NB   = (NBCD > NDIG) ? NBCD : NDIG;
  localparam int CW   = $clog2(BIN_W + 1);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state_q, state_d;
  logic [NB*4-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NDIG*8-1:0] hex_q, hex_d, hex_enc;
  logic              done_q, done_d;
  logic              ovf;
  logic              seen;

  always_ff @(posedge ADC_CLK_10) begin
    if (!reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Digits above the display width only become nonzero when the value cannot be shown.
  always_comb begin
    hex_enc = '1;
    ovf     = 1'b0;
    seen    = 1'b0;
    for (int i = NDIG; i < NB; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) ovf = 1'b1;
    end
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (bcd_q[i*4 +: 4] != 4'd0) seen = 1'b1;
      if (ovf)
        hex_enc[i*8 +: 8] = 8'hBF;
      else if (i == 0 || seen || !bus.blank_lz)
        hex_enc[i*8 +: 8] = seg7(bcd_q[i*4 +: 4]);
      else
        hex_enc[i*8 +: 8] = 8'hFF;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d   = bus.in_bin;
          bcd_d   = '0;
          cnt_d   = CW'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          bcd_d = {bcd_adj[NB*4-2:0], bin_q[BIN_W-1]};
          bin_d = bin_q << 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        hex_d   = hex_enc;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.hex_out   = hex_q;
  assign bus.conv_done = done_q;

endmodule

// File: tb/tb_bcd_hex_display.sv
// tb/tb_bcd_hex_display.sv - scoreboard bench for the BCD display stage
module tb_bcd_hex_display;
  localparam int BIN_W = 7;
  localparam int NDIG  = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_hex_display_if #(.BIN_W(BIN_W), .NDIG(NDIG)) bus ();

  bcd_hex_display #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
    .ADC_CLK_10 (clk),
    .reset      (reset),
    .bus        (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.conv_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_conv_done: hex_out %h with nothing pending", bus.hex_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("hex_out", 32'(bus.hex_out), 32'(e));
      end
    end
  end

  task automatic accept(input int v, input bit blk);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_bin   = v[BIN_W-1:0];
    bus.blank_lz = blk;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_bin   = ~bus.in_bin;
  endtask

  task automatic wait_done(input bit chk_lat);
    int n;
    int low;
    n = 0;
    low = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.conv_done !== 1'b1 && bus.in_ready === 1'b0) low++;
    end while (bus.conv_done !== 1'b1 && n < 40);
    if (bus.conv_done !== 1'b1) check("conv_done_timeout", 32'(bus.conv_done), 32'd1);
    if (chk_lat) begin
      check("in_ready_low_cycles", 32'(low), 32'd9);
      check("in_ready_at_done", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic send(input int v, input bit blk, input logic [15:0] exp, input bit chk_lat);
    exp_q.push_back(exp);
    accept(v, blk);
    wait_done(chk_lat);
  endtask

  initial begin
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bin   = '0;
    bus.blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hex_out", 32'(bus.hex_out), 32'h0000_FFFF);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_conv_done", 32'(bus.conv_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    send(42, 1'b0, 16'h99A4, 1'b1);
    send(5, 1'b1, 16'hFF92, 1'b1);
    send(5, 1'b0, 16'hC092, 1'b0);
    send(0, 1'b1, 16'hFFC0, 1'b0);
    send(0, 1'b0, 16'hC0C0, 1'b0);
    send(10, 1'b1, 16'hF9C0, 1'b0);
    send(127, 1'b0, 16'hBFBF, 1'b0);
    send(100, 1'b1, 16'hBFBF, 1'b0);
    send(99, 1'b1, 16'h9090, 1'b0);

    // A second value offered mid-conversion must be dropped, not queued.
    exp_q.push_back(16'hF9B0);
    accept(13, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_bin   = 7'd77;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_done(1'b0);
    repeat (15) @(negedge clk);

    accept(42, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_hex_out", 32'(bus.hex_out), 32'h0000_FFFF);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_conv_done", 32'(bus.conv_done), 32'd0);
    repeat (15) @(negedge clk);

    send(7, 1'b1, 16'hFFF8, 1'b1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
